// File: rtl/msrv32_pkg.sv
// Shared AHB-Lite encodings and the data-memory bridge FSM state type.
package msrv32_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_ERR
    } bridge_state_t;

endpackage

// File: rtl/msrv32_mask_to_hsize.sv
// Decodes a store byte mask into the AHB transfer size and the low address bits.
module msrv32_mask_to_hsize
    import msrv32_pkg::*;
(
    input  logic [3:0] mask,
    output logic [2:0] hsize,
    output logic [1:0] offset,
    output logic       illegal
);

    always_comb begin
        // NOTE: every output gets a default first, so no path through the case can infer a latch.
        hsize   = HSIZE_WORD;
        offset  = 2'd0;
        illegal = 1'b0;
        case (mask)
            4'b1111: ;
            4'b0011: hsize = HSIZE_HALF;
            4'b1100: begin hsize = HSIZE_HALF; offset = 2'd2; end
            4'b0001: begin hsize = HSIZE_BYTE; offset = 2'd0; end
            4'b0010: begin hsize = HSIZE_BYTE; offset = 2'd1; end
            4'b0100: begin hsize = HSIZE_BYTE; offset = 2'd2; end
            4'b1000: begin hsize = HSIZE_BYTE; offset = 2'd3; end
            // Non-contiguous masks fall back to a word access and are flagged.
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/msrv32_dmem_ahb_bridge.sv
// Single-outstanding AHB-Lite master for pipeline loads and stores; reports
// read data, bus errors and a stall back to the core.
module msrv32_dmem_ahb_bridge
    import msrv32_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              ms_riscv32_mp_clk_in,
    input  logic              ms_riscv32_mp_rst_in,
    input  logic [ADDR_W-1:0] dmaddr_in,
    input  logic [DATA_W-1:0] dmdata_in,
    input  logic [3:0]        dmwr_mask_in,
    input  logic              dmwr_req_in,
    input  logic              dmrd_req_in,
    input  logic              hready_in,
    input  logic              hresp_in,
    input  logic [DATA_W-1:0] hrdata_in,
    output logic [ADDR_W-1:0] haddr_out,
    output logic              hwrite_out,
    output logic [2:0]        hsize_out,
    output logic [1:0]        htrans_out,
    output logic [DATA_W-1:0] hwdata_out,
    output logic              ahb_ready_out,
    output logic              stall_out,
    output logic [DATA_W-1:0] rdata_out,
    output logic              rd_valid_out,
    output logic              bus_err_out
);

    bridge_state_t     state;
    logic [DATA_W-1:0] data_q;
    logic              illegal_q;
    logic [2:0]        mask_hsize;
    logic [1:0]        mask_offset;
    logic              mask_illegal;
    logic              accept;

    msrv32_mask_to_hsize u_mask_to_hsize (
        .mask    (dmwr_mask_in),
        .hsize   (mask_hsize),
        .offset  (mask_offset),
        .illegal (mask_illegal)
    );

    assign accept        = (state == ST_IDLE) && (dmwr_req_in || dmrd_req_in) && !ms_riscv32_mp_rst_in;
    assign ahb_ready_out = (state == ST_IDLE);
    assign stall_out     = (state != ST_IDLE) || accept;

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // branch sees the pre-edge values regardless of statement order.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state        <= ST_IDLE;
            haddr_out    <= '0;
            hwrite_out   <= 1'b0;
            hsize_out    <= 3'b000;
            htrans_out   <= HTRANS_IDLE;
            hwdata_out   <= '0;
            rdata_out    <= '0;
            rd_valid_out <= 1'b0;
            bus_err_out  <= 1'b0;
            data_q       <= '0;
            illegal_q    <= 1'b0;
        end else begin
            rd_valid_out <= 1'b0;
            bus_err_out  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (dmwr_req_in) begin
                        // A store wins over a simultaneous load; the load is dropped.
                        state      <= ST_ADDR;
                        htrans_out <= HTRANS_NONSEQ;
                        hwrite_out <= 1'b1;
                        hsize_out  <= mask_hsize;
                        haddr_out  <= {dmaddr_in[ADDR_W-1:2], dmaddr_in[1:0] | mask_offset};
                        data_q     <= dmdata_in;
                        illegal_q  <= mask_illegal;
                    end else if (dmrd_req_in) begin
                        state      <= ST_ADDR;
                        htrans_out <= HTRANS_NONSEQ;
                        hwrite_out <= 1'b0;
                        hsize_out  <= HSIZE_WORD;
                        haddr_out  <= {dmaddr_in[ADDR_W-1:2], 2'b00};
                        data_q     <= dmdata_in;
                        illegal_q  <= 1'b0;
                    end
                end
                ST_ADDR: begin
                    if (hready_in) begin
                        state      <= ST_DATA;
                        htrans_out <= HTRANS_IDLE;
                        hwdata_out <= data_q;
                    end
                end
                ST_DATA: begin
                    if (hresp_in) begin
                        // A one-cycle error response is tolerated and finished immediately.
                        if (hready_in) begin
                            state       <= ST_IDLE;
                            bus_err_out <= 1'b1;
                        end else begin
                            state <= ST_ERR;
                        end
                    end else if (hready_in) begin
                        state <= ST_IDLE;
                        if (!hwrite_out) begin
                            rdata_out    <= hrdata_in;
                            rd_valid_out <= 1'b1;
                        end
                        if (illegal_q) begin
                            bus_err_out <= 1'b1;
                        end
                    end
                end
                ST_ERR: begin
                    if (hready_in) begin
                        state       <= ST_IDLE;
                        bus_err_out <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
